// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester ids, FSM states and
// pointer helpers.
package dmem_arb_pkg;

  localparam int REQ_N = 3;

  typedef enum logic [1:0] {
    REQ_S = 2'd0,
    REQ_V = 2'd1,
    REQ_H = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    HLOCK   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Next round-robin start position after a grant to id (mod 3).
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] nxt;
    if (id == 2'd2) begin
      nxt = 2'd0;
    end else begin
      nxt = id + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: the first unmasked requester at or
// after ptr wins; result is one-hot (all zero when nobody is eligible).
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] ptr,
  output logic [2:0] win
);

  logic [2:0] elig_s;
  logic [2:0] rot_s;
  logic [2:0] first_s;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    elig_s = req & ~mask;
    case (ptr)
      2'd0:    rot_s = elig_s;
      2'd1:    rot_s = {elig_s[0], elig_s[2:1]};
      2'd2:    rot_s = {elig_s[1:0], elig_s[2]};
      default: rot_s = elig_s;
    endcase
    if (rot_s[0]) begin
      first_s = 3'b001;
    end else if (rot_s[1]) begin
      first_s = 3'b010;
    end else if (rot_s[2]) begin
      first_s = 3'b100;
    end else begin
      first_s = 3'b000;
    end
    case (ptr)
      2'd0:    win = first_s;
      2'd1:    win = {first_s[1:0], first_s[2]};
      2'd2:    win = {first_s[0], first_s[2:1]};
      default: win = first_s;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter for scalar (S), vector (V) and host (H)
// requesters with host lock. Optional grant/conflict counters: DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int SDATA_W  = 16,
  parameter int VDATA_W  = 256,
  parameter int LOCK_MAX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_req,
  input  logic               v_req,
  input  logic               h_req,
  input  logic               s_we,
  input  logic               v_we,
  input  logic               h_we,
  input  logic [ADDR_W-1:0]  s_addr,
  input  logic [ADDR_W-1:0]  v_addr,
  input  logic [ADDR_W-1:0]  h_addr,
  input  logic [SDATA_W-1:0] s_wdata,
  input  logic [SDATA_W-1:0] h_wdata,
  input  logic [VDATA_W-1:0] v_wdata,
  input  logic               h_lock,
  output logic               s_gnt,
  output logic               v_gnt,
  output logic               h_gnt,
  output logic               s_rvalid,
  output logic               v_rvalid,
  output logic               h_rvalid,
  output logic [SDATA_W-1:0] s_rdata,
  output logic [SDATA_W-1:0] h_rdata,
  output logic [VDATA_W-1:0] v_rdata,
  output logic               mem_we,
  output logic               mem_src_sel,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [SDATA_W-1:0] mem_wdata_a,
  output logic [VDATA_W-1:0] mem_wdata_b,
  input  logic [SDATA_W-1:0] mem_q_a,
  input  logic [VDATA_W-1:0] mem_q_b
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        perf_s_cnt,
  output logic [31:0]        perf_v_cnt,
  output logic [31:0]        perf_h_cnt,
  output logic [31:0]        perf_conflict_cnt
`endif
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_t       state_r, state_s;
  logic [1:0]       rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_s;
  logic             rd_pend_r;
  logic [1:0]       rd_owner_r;
  logic [2:0]       req_s, mask_s, win_s;
  logic [1:0]       win_id_s;
  logic             any_gnt_s;

  assign req_s = {h_req, v_req, s_req};

  // Lock states restrict who may compete: HLOCK admits only H, RELEASE excludes H.
  always_comb begin
    case (state_r)
      ARB:     mask_s = 3'b000;
      HLOCK:   mask_s = 3'b011;
      RELEASE: mask_s = 3'b100;
      default: mask_s = 3'b111;
    endcase
  end

  rr_pick3 u_pick (
    .req  (req_s),
    .mask (mask_s),
    .ptr  (rr_ptr_r),
    .win  (win_s)
  );

  assign s_gnt     = win_s[0];
  assign v_gnt     = win_s[1];
  assign h_gnt     = win_s[2];
  assign any_gnt_s = |win_s;

  // Steer the winner's request onto the memory port; idle port drives zeros.
  always_comb begin
    mem_we      = 1'b0;
    mem_src_sel = 1'b0;
    mem_addr    = '0;
    mem_wdata_a = '0;
    mem_wdata_b = '0;
    win_id_s    = REQ_S;
    if (win_s[0]) begin
      mem_we      = s_we;
      mem_addr    = s_addr;
      mem_wdata_a = s_wdata;
      win_id_s    = REQ_S;
    end else if (win_s[1]) begin
      mem_we      = v_we;
      mem_src_sel = 1'b1;
      mem_addr    = v_addr;
      mem_wdata_b = v_wdata;
      win_id_s    = REQ_V;
    end else if (win_s[2]) begin
      mem_we      = h_we;
      mem_addr    = h_addr;
      mem_wdata_a = h_wdata;
      win_id_s    = REQ_H;
    end else begin
      win_id_s    = REQ_S;
    end
  end

  // Next-state logic; lock_cnt counts locked H grants including the one that took the lock.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      ARB: begin
        if (any_gnt_s) begin
          rr_ptr_s = rr_next(win_id_s);
          if (win_s[2] && h_lock) begin
            state_s    = HLOCK;
            lock_cnt_s = CNT_W'(1);
          end else begin
            state_s    = ARB;
          end
        end else begin
          rr_ptr_s = rr_ptr_r;
        end
      end
      HLOCK: begin
        if (!h_lock) begin
          state_s    = ARB;
          lock_cnt_s = '0;
        end else if (win_s[2]) begin
          if (lock_cnt_r == CNT_W'(LOCK_MAX - 1)) begin
            state_s    = RELEASE;
            lock_cnt_s = '0;
          end else begin
            lock_cnt_s = lock_cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = HLOCK;
        end
      end
      RELEASE: begin
        state_s = ARB;
      end
      default: begin
        state_s    = ARB;
        lock_cnt_s = '0;
      end
    endcase
  end

  // FSM, pointer and pending-read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB;
      rr_ptr_r   <= REQ_S;
      lock_cnt_r <= '0;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= REQ_S;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      lock_cnt_r <= lock_cnt_s;
      rd_pend_r  <= any_gnt_s & ~mem_we;
      rd_owner_r <= win_id_s;
    end
  end

  assign s_rvalid = rd_pend_r && (rd_owner_r == REQ_S);
  assign v_rvalid = rd_pend_r && (rd_owner_r == REQ_V);
  assign h_rvalid = rd_pend_r && (rd_owner_r == REQ_H);
  assign s_rdata  = s_rvalid ? mem_q_a : '0;
  assign h_rdata  = h_rvalid ? mem_q_a : '0;
  assign v_rdata  = v_rvalid ? mem_q_b : '0;

`ifdef DMEM_ARB_PERF_EN
  logic conflict_s;
  assign conflict_s = (s_req & v_req) | (s_req & h_req) | (v_req & h_req);

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_s_cnt        <= 32'd0;
      perf_v_cnt        <= 32'd0;
      perf_h_cnt        <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else if (perf_clr) begin
      perf_s_cnt        <= 32'd0;
      perf_v_cnt        <= 32'd0;
      perf_h_cnt        <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else begin
      if (win_s[0] && (perf_s_cnt != 32'hFFFF_FFFF)) perf_s_cnt <= perf_s_cnt + 32'd1;
      if (win_s[1] && (perf_v_cnt != 32'hFFFF_FFFF)) perf_v_cnt <= perf_v_cnt + 32'd1;
      if (win_s[2] && (perf_h_cnt != 32'hFFFF_FFFF)) perf_h_cnt <= perf_h_cnt + 32'd1;
      if (conflict_s && (perf_conflict_cnt != 32'hFFFF_FFFF))
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the sharing rules.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int SW = 16;
  localparam int VW = 256;
  localparam int LM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [2:0]    r_req, r_we;
  logic [AW-1:0] r_addr [3];
  logic [SW-1:0] r_wd [3];
  logic [VW-1:0] v_wdata;
  logic          h_lock;
  logic [SW-1:0] mem_q_a;
  logic [VW-1:0] mem_q_b;

  logic          s_gnt, v_gnt, h_gnt, s_rvalid, v_rvalid, h_rvalid;
  logic [SW-1:0] s_rdata, h_rdata, mem_wdata_a;
  logic [VW-1:0] v_rdata, mem_wdata_b;
  logic          mem_we, mem_src_sel;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_PERF_EN
  logic          perf_clr;
  logic [31:0]   perf_s_cnt, perf_v_cnt, perf_h_cnt, perf_conflict_cnt;
  longint        m_pc [4];
`endif

  dmem_arbiter #(.ADDR_W(AW), .SDATA_W(SW), .VDATA_W(VW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req(r_req[0]), .v_req(r_req[1]), .h_req(r_req[2]),
    .s_we(r_we[0]), .v_we(r_we[1]), .h_we(r_we[2]),
    .s_addr(r_addr[0]), .v_addr(r_addr[1]), .h_addr(r_addr[2]),
    .s_wdata(r_wd[0]), .h_wdata(r_wd[2]), .v_wdata(v_wdata),
    .h_lock(h_lock),
    .s_gnt(s_gnt), .v_gnt(v_gnt), .h_gnt(h_gnt),
    .s_rvalid(s_rvalid), .v_rvalid(v_rvalid), .h_rvalid(h_rvalid),
    .s_rdata(s_rdata), .h_rdata(h_rdata), .v_rdata(v_rdata),
    .mem_we(mem_we), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
    .mem_wdata_a(mem_wdata_a), .mem_wdata_b(mem_wdata_b),
    .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
`ifdef DMEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_s_cnt(perf_s_cnt), .perf_v_cnt(perf_v_cnt),
    .perf_h_cnt(perf_h_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: who may be served next (ptr), lock mode (0 open, 1 host-locked,
  // 2 one-cycle release), locked grant count, outstanding read owner.
  int m_ptr, m_mode, m_cnt, m_owner, m_win;
  bit m_pend;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      int c;
      bit ok;
      c  = (m_ptr + k) % 3;
      ok = (m_mode == 0) || (m_mode == 1 && c == 2) || (m_mode == 2 && c != 2);
      if (r_req[c] && ok) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_mode = 0; m_cnt = 0; m_pend = 1'b0; m_owner = 0; m_win = -1;
`ifdef DMEM_ARB_PERF_EN
    for (int i = 0; i < 4; i++) m_pc[i] = 0;
`endif
  endtask

  // Compare every output against the model at the falling edge.
  task automatic sample();
    logic [2:0]    eg, erv;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [SW-1:0] ewa;
    logic [VW-1:0] ewb;
    @(negedge clk);
    m_win = model_pick();
    eg = 3'b000; ewe = 1'b0; ea = '0; ewa = '0; ewb = '0;
    if (m_win >= 0) begin
      eg  = 3'(1 << m_win);
      ewe = r_we[m_win];
      ea  = r_addr[m_win];
      if (m_win == 1) ewb = v_wdata;
      else            ewa = r_wd[m_win];
    end
    erv = m_pend ? 3'(1 << m_owner) : 3'b000;
    check("gnt", VW'({h_gnt, v_gnt, s_gnt}), VW'(eg));
    check("mem_we", VW'(mem_we), VW'(ewe));
    check("mem_src_sel", VW'(mem_src_sel), VW'(m_win == 1));
    check("mem_addr", VW'(mem_addr), VW'(ea));
    check("mem_wdata_a", VW'(mem_wdata_a), VW'(ewa));
    check("mem_wdata_b", mem_wdata_b, ewb);
    check("rvalid", VW'({h_rvalid, v_rvalid, s_rvalid}), VW'(erv));
    check("s_rdata", VW'(s_rdata), VW'(erv[0] ? mem_q_a : 16'h0000));
    check("h_rdata", VW'(h_rdata), VW'(erv[2] ? mem_q_a : 16'h0000));
    check("v_rdata", v_rdata, erv[1] ? mem_q_b : {VW{1'b0}});
`ifdef DMEM_ARB_PERF_EN
    check("perf_s", VW'(perf_s_cnt), VW'(m_pc[0]));
    check("perf_v", VW'(perf_v_cnt), VW'(m_pc[1]));
    check("perf_h", VW'(perf_h_cnt), VW'(m_pc[2]));
    check("perf_conflict", VW'(perf_conflict_cnt), VW'(m_pc[3]));
`endif
  endtask

  // Clock edge: apply the sharing rules to the model, then leave 1ns for drivers.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
`ifdef DMEM_ARB_PERF_EN
      if (perf_clr) begin
        for (int i = 0; i < 4; i++) m_pc[i] = 0;
      end else begin
        if (m_win >= 0) m_pc[m_win]++;
        if ($countones(r_req) >= 2) m_pc[3]++;
      end
`endif
      m_pend  = 1'b0;
      m_owner = m_win;
      if (m_win >= 0) m_pend = !r_we[m_win];
      case (m_mode)
        0: if (m_win >= 0) begin
             m_ptr = (m_win + 1) % 3;
             if (m_win == 2 && h_lock) begin m_mode = 1; m_cnt = 1; end
           end
        1: if (!h_lock) begin
             m_mode = 0; m_cnt = 0;
           end else if (m_win == 2) begin
             m_cnt++;
             if (m_cnt == LM) begin m_mode = 2; m_cnt = 0; end
           end
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic clear_inputs();
    r_req = 3'b000; r_we = 3'b000; h_lock = 1'b0; v_wdata = '0;
    mem_q_a = '0; mem_q_b = '0;
    for (int i = 0; i < 3; i++) begin r_addr[i] = '0; r_wd[i] = '0; end
`ifdef DMEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    sample();
    check("rst_gnt", VW'({h_gnt, v_gnt, s_gnt}), VW'(3'b000));
    check("rst_rvalid", VW'({h_rvalid, v_rvalid, s_rvalid}), VW'(3'b000));
    advance();
    rst_n = 1'b1;
  endtask

  task automatic new_req(input int i);
    r_req[i]  = ($urandom_range(0, 2) != 0);
    r_we[i]   = $urandom_range(0, 1) == 1;
    r_addr[i] = $urandom;
    r_wd[i]   = 16'($urandom);
    if (i == 1) v_wdata = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
  endtask

  logic [VW-1:0] pat;
  logic [2:0]    exp_seq [6];
  logic [2:0]    lock_seq [6];

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    do_reset();

    // Single scalar read, data returns the next cycle.
    r_req[0] = 1'b1; r_addr[0] = 32'h10;
    sample();
    check("s_read_gnt", VW'(s_gnt), VW'(1'b1));
    check("s_read_sel", VW'(mem_src_sel), VW'(1'b0));
    advance();
    r_req[0] = 1'b0; mem_q_a = 16'hBEEF;
    sample();
    check("s_rdata_beef", VW'(s_rdata), VW'(16'hBEEF));
    advance();

    // Vector write: wide data on port b, no response.
    pat = {8{32'hA5C3_0F96}};
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h4; v_wdata = pat;
    sample();
    check("v_write_we", VW'(mem_we), VW'(1'b1));
    check("v_write_wdata", mem_wdata_b, pat);
    advance();
    r_req[1] = 1'b0;
    sample();
    check("v_write_no_rvalid", VW'(v_rvalid), VW'(1'b0));
    advance();

    // Everyone requesting from reset rotates S,V,H.
    do_reset();
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    r_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("rr_order", VW'({h_gnt, v_gnt, s_gnt}), VW'(exp_seq[i]));
      advance();
    end
    r_req = 3'b000;
    sample();
`ifdef DMEM_ARB_PERF_EN
    check("perf_conflict_6", VW'(perf_conflict_cnt), VW'(32'd6));
`endif
    advance();

    // Host lock with S competing: S, 4 locked H grants, release to S.
    do_reset();
    lock_seq = '{3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    r_req = 3'b101; r_we = 3'b101; h_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("lock_seq", VW'({h_gnt, v_gnt, s_gnt}), VW'(lock_seq[i]));
      advance();
    end
    for (int i = 0; i < 4; i++) begin sample(); advance(); end

    // Back-to-back reads S then H.
    do_reset();
    r_req = 3'b101; r_addr[0] = 32'h20; r_addr[2] = 32'h30;
    sample(); advance();
    r_req[0] = 1'b0; mem_q_a = 16'h1234;
    sample();
    check("b2b_s_rdata", VW'(s_rdata), VW'(16'h1234));
    advance();
    r_req[2] = 1'b0; mem_q_a = 16'h5678;
    sample();
    check("b2b_h_rdata", VW'(h_rdata), VW'(16'h5678));
    advance();

    // Reset right after a vector read grant drops the response.
    r_req[1] = 1'b1; r_we[1] = 1'b0; mem_q_b = {VW{1'b1}};
    sample(); advance();
    rst_n = 1'b0; clear_inputs(); model_reset();
    sample();
    check("rst_drop_rvalid", VW'(v_rvalid), VW'(1'b0));
    advance();
    rst_n = 1'b1;
    r_req = 3'b111;
    sample();
    check("post_rst_ptr_s", VW'({h_gnt, v_gnt, s_gnt}), VW'(3'b001));
    advance();
    r_req = 3'b000;

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      sample();
      advance();
      for (int i = 0; i < 3; i++) begin
        if (m_win == i || !r_req[i]) new_req(i);
      end
      if ($urandom_range(0, 3) == 0) h_lock = ~h_lock;
      mem_q_a = 16'($urandom);
      mem_q_b = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
`ifdef DMEM_ARB_PERF_EN
      perf_clr = ($urandom_range(0, 63) == 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between three requesters: scalar pipeline (S), vector pipeline (V) and host loader (H).
- Arbitration is round-robin with a host lock for bulk load/dump.
- Drives dmem's w_enable/src_sel/addr/w_data_a/w_data_b and routes q_a/q_b back to the owner as a 1-cycle-latency read response.
- Sits between the execute/memory stage, the host loader and dmem.

Parameters:
ADDR_W, 32, address width of all requester ports and mem_addr
SDATA_W, 16, scalar data width (S and H ports, q_a)
VDATA_W, 256, vector data width (V port, q_b)
LOCK_MAX, 64, max consecutive host-locked grants before a forced one-cycle release

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_req/v_req/h_req  in  1  request valid per requester
s_we/v_we/h_we  in  1  write (1) / read (0)
s_addr/v_addr/h_addr  in  ADDR_W  request address
s_wdata, h_wdata  in  SDATA_W  scalar write data
v_wdata  in  VDATA_W  vector write data
h_lock  in  1  host requests exclusive ownership
s_gnt/v_gnt/h_gnt  out  1  request accepted this cycle
s_rvalid/v_rvalid/h_rvalid  out  1  read data valid
s_rdata, h_rdata  out  SDATA_W  read data (from q_a)
v_rdata  out  VDATA_W  read data (from q_b)
mem_we  out  1  to dmem w_enable
mem_src_sel  out  1  to dmem src_sel (0 scalar, 1 vector)
mem_addr  out  ADDR_W  to dmem addr
mem_wdata_a  out  SDATA_W  to dmem w_data_a
mem_wdata_b  out  VDATA_W  to dmem w_data_b
mem_q_a  in  SDATA_W  from dmem q_a
mem_q_b  in  VDATA_W  from dmem q_b

Behaviour:
- Handshake: a request is consumed on the cycle req && gnt. The requester holds req/we/addr/wdata stable until granted. At most one gnt per cycle. gnt is combinational from req and registered state.
- Memory drive, combinational from the winner:
  - mem_we = winner's we.
  - mem_src_sel = 1 only for V.
  - mem_addr/wdata muxed from the winner.
  - No winner: mem_we=0, mem_src_sel=0, addr/wdata=0.
- Round-robin pointer rr_ptr ∈ {S,V,H}, reset S. Priority order starts at rr_ptr. After any grant in ARB, rr_ptr = winner+1 (mod 3). No grant: pointer unchanged.
- FSM states: ARB, HLOCK, RELEASE.
  - ARB -> HLOCK: when H is granted with h_lock=1.
  - In HLOCK: only H can be granted, S/V gnt=0. lock_cnt increments per H grant.
  - HLOCK -> ARB: when h_lock=0.
  - HLOCK -> RELEASE: when lock_cnt reaches LOCK_MAX-1 on a grant.
  - RELEASE lasts one cycle: H is masked, S/V arbitrate round-robin, then -> ARB. lock_cnt clears on HLOCK exit.
  - h_lock with no h_req in HLOCK: the memory idles and the lock is held.
- Read response: on a read grant, register rd_pend=1 and rd_owner. The next cycle asserts the owner's rvalid for exactly one cycle. rdata is routed combinationally from mem_q_a (S/H) or mem_q_b (V). Reads are back-to-back capable: a grant is allowed while a response is in flight. Writes produce no rvalid.
- rdata when rvalid=0: held at 0.
- Reset values: all gnt/rvalid/rdata 0, mem_we 0, state ARB, rr_ptr S, lock_cnt 0, rd_pend 0. Reset mid-read drops the pending response (no rvalid after reset release).
- Address is passed through unmodified; dmem truncates it.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds outputs perf_s_cnt/perf_v_cnt/perf_h_cnt (32-bit grant counters) and perf_conflict_cnt (cycles with ≥2 reqs). All counters saturate at all-ones, reset 0, and clear on input perf_clr.
- Undefined: these ports and the logic are absent.

Decomposition:
- Package dmem_arb_pkg: enum req_id_t {REQ_S, REQ_V, REQ_H}, enum arb_state_t {ARB, HLOCK, RELEASE}, localparam REQ_N=3.
- Sub-module rr_pick3: combinational 3-way round-robin picker taking req vector, mask and pointer, returning a one-hot winner.

Test Plan:
- Single S read at addr 0x10, then mem_q_a=0xBEEF -> s_gnt same cycle, s_rvalid next cycle with s_rdata=0xBEEF; mem_src_sel=0.
- V write addr 0x4 with 256-bit pattern -> mem_we=1, mem_src_sel=1, mem_wdata_b=pattern; no v_rvalid.
- S,V,H requesting every cycle from reset -> grant order S,V,H,S,V,H; perf conflict count=6 after 6 cycles when enabled.
- H lock with LOCK_MAX=4, S also requesting -> 4 H grants, 1 RELEASE cycle granting S, then H resumes lock.
- Back-to-back reads S then H -> rvalid on S then H in consecutive cycles with correct data routing.
- rst_n asserted the cycle after a V read grant -> v_rvalid never asserts; after release state ARB, rr_ptr=S.
